// File: rtl/im_gen_decode.sv
// Decode-stage immediate generator: extracts and extends the immediate selected
// by sel and queues {imm, sel} in a 2-entry FIFO toward the execute stage.
module im_gen_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in1,
  input  logic [2:0]  sel,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out1,
  output logic [2:0]  out_sel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err,
  input  logic        err_clr
);

  localparam logic [2:0] SEL_I     = 3'b000;
  localparam logic [2:0] SEL_S     = 3'b001;
  localparam logic [2:0] SEL_B     = 3'b010;
  localparam logic [2:0] SEL_U     = 3'b011;
  localparam logic [2:0] SEL_J     = 3'b100;
  localparam logic [2:0] SEL_SHAMT = 3'b101;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } cnt_state_t;

  cnt_state_t  state_reg, state_next;
  logic        wr_ptr_reg, wr_ptr_next;
  logic        rd_ptr_reg, rd_ptr_next;
  logic        err_reg, err_next;
  logic [31:0] imm;
  logic        illegal;
  logic        push, pop;
  logic [34:0] head;

  // Immediate extraction; every signed format replicates in1[31].
  always_comb begin
    imm     = 32'h0;
    illegal = 1'b0;
    case (sel)
      SEL_I:     imm = {{20{in1[31]}}, in1[31:20]};
      SEL_S:     imm = {{20{in1[31]}}, in1[31:25], in1[11:7]};
      SEL_B:     imm = {{19{in1[31]}}, in1[31], in1[7], in1[30:25], in1[11:8], 1'b0};
      SEL_U:     imm = {in1[31:12], 12'b0};
      SEL_J:     imm = {{11{in1[31]}}, in1[31], in1[19:12], in1[20], in1[30:21], 1'b0};
      SEL_SHAMT: imm = {27'b0, in1[24:20]};
      default: begin
        imm     = 32'h0;
        illegal = 1'b1;
      end
    endcase
  end

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Count state machine: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Count state machine: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY: if (push) state_next = ONE;
      ONE: begin
        if (push && !pop)      state_next = FULL;
        else if (pop && !push) state_next = EMPTY;
        else                   state_next = ONE;
      end
      FULL:  if (pop) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  // Count state machine: outputs depend on registered state only
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state_reg)
      EMPTY: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      ONE: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
      end
      FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  assign wr_ptr_next = wr_ptr_reg ^ push;
  assign rd_ptr_next = rd_ptr_reg ^ pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Storage entries {sel, imm}; head must be readable in the cycle after a push.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      localparam logic IDX = 1'(gi);
      logic [34:0] entry_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          entry_reg <= '0;
        end else if (push && (wr_ptr_reg == IDX)) begin
          entry_reg <= {sel, imm};
        end
      end
    end
  endgenerate

  assign head    = rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;
  assign out1    = head[31:0];
  assign out_sel = head[34:32];

  // Set has priority over clear so an illegal push is never lost.
  always_comb begin
    err_next = err_reg;
    if (push && illegal) begin
      err_next = 1'b1;
    end else if (err_clr) begin
      err_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= err_next;
    end
  end

  assign err = err_reg;

endmodule

// File: tb/tb_im_gen_decode.sv
// Scoreboard bench for im_gen_decode: expected {sel, imm} queued on accept,
// compared on every pop, plus directed checks of latency, backpressure and err.
module tb_im_gen_decode;

  logic        clk;
  logic        rst;
  logic [31:0] in1;
  logic [2:0]  sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out1;
  logic [2:0]  out_sel;
  logic        out_valid;
  logic        out_ready;
  logic        err;
  logic        err_clr;

  int checks = 0;
  int errors = 0;

  logic [34:0] sb[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_out1  = 32'h0;

  im_gen_decode dut (
    .clk      (clk),
    .rst      (rst),
    .in1      (in1),
    .sel      (sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out1     (out1),
    .out_sel  (out_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err      (err),
    .err_clr  (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference built from shifts and masks rather than bit concatenation.
  function automatic logic [31:0] ref_imm(input logic [31:0] w, input logic [2:0] s);
    logic [31:0] sx20;
    logic [31:0] sx11;
    sx20 = 32'($signed(w) >>> 20);
    sx11 = 32'($signed(w) >>> 11);
    case (s)
      3'd0: ref_imm = sx20;
      3'd1: ref_imm = (sx20 & 32'hFFFF_FFE0) | ((w >> 7) & 32'h1F);
      3'd2: ref_imm = (sx20 & 32'hFFFF_F000) | (32'(w[7]) << 11)
                      | (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1);
      3'd3: ref_imm = w & 32'hFFFF_F000;
      3'd4: ref_imm = (sx11 & 32'hFFF0_0000) | (w & 32'h000F_F000)
                      | (32'(w[20]) << 11) | (((w >> 21) & 32'h3FF) << 1);
      3'd5: ref_imm = (w >> 20) & 32'h1F;
      default: ref_imm = 32'h0;
    endcase
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && out_valid) chk("hold_out1", out1, prev_out1);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          logic [34:0] e;
          e = sb.pop_front();
          chk("sb_imm", out1, e[31:0]);
          chk("sb_sel", 32'(out_sel), 32'(e[34:32]));
          $display("pop imm=%08h sel=%0d", out1, out_sel);
        end
      end
      if (in_valid && in_ready) sb.push_back({sel, ref_imm(in1, sel)});
      prev_stall = out_valid && !out_ready;
      prev_out1  = out1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] vec_in[4]  = '{32'hFE000EE3, 32'hFE002C23, 32'h123450B7, 32'h0080006F};
  logic [2:0]  vec_sel[4] = '{3'b010, 3'b001, 3'b011, 3'b100};
  logic [31:0] vec_exp[4] = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h00000008};

  initial begin
    logic [31:0] a_in, b_in, c_in, cur_in;
    logic [2:0]  cur_sel;
    int          budget;

    rst = 1'b1; in1 = '0; sel = '0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out1", out1, 32'h0);
    chk("rst_out_sel", 32'(out_sel), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    step();
    rst = 1'b0;

    // I-type, single-cycle latency
    in1 = 32'hFFF00093; sel = 3'b000; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("i_valid", 32'(out_valid), 32'd1);
    chk("i_out1", out1, 32'hFFFFFFFF);
    chk("i_sel", 32'(out_sel), 32'd0);
    step();

    // B/S/U/J back to back at full throughput
    for (int i = 0; i < 4; i++) begin
      in1 = vec_in[i]; sel = vec_sel[i]; in_valid = 1'b1;
      step();
      chk("fmt_out1", out1, vec_exp[i]);
      chk("fmt_sel", 32'(out_sel), 32'(vec_sel[i]));
    end
    in_valid = 1'b0;
    step();

    // Backpressure: third entry held off until the consumer drains
    a_in = $urandom; b_in = $urandom; c_in = $urandom;
    out_ready = 1'b0;
    in1 = a_in; sel = 3'd0; in_valid = 1'b1;
    step();
    chk("bp_ready_one", 32'(in_ready), 32'd1);
    in1 = b_in; sel = 3'd1;
    step();
    chk("bp_ready_full", 32'(in_ready), 32'd0);
    in1 = c_in; sel = 3'd4;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_stall_out1", out1, ref_imm(a_in, 3'd0));
      chk("bp_stall_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_pop_a", out1, ref_imm(b_in, 3'd1));
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_c_head", out1, ref_imm(c_in, 3'd4));
    step();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Push and pop together at count 1
    out_ready = 1'b0;
    in1 = $urandom; sel = 3'd3; in_valid = 1'b1;
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cur_in = $urandom; cur_sel = 3'($urandom_range(0, 5));
      in1 = cur_in; sel = cur_sel;
      step();
      chk("pp_out1", out1, ref_imm(cur_in, cur_sel));
      chk("pp_count1", {30'b0, out_valid, in_ready}, 32'd3);
    end
    in_valid = 1'b0;
    step();

    // Illegal select and err priority
    in1 = $urandom; sel = 3'b110; in_valid = 1'b1;
    step();
    chk("ill_out1", out1, 32'h0);
    chk("ill_sel", 32'(out_sel), 32'd6);
    chk("ill_err", 32'(err), 32'd1);
    sel = 3'b111; err_clr = 1'b1;
    step();
    in_valid = 1'b0;
    chk("ill_set_wins", 32'(err), 32'd1);
    step();
    err_clr = 1'b0;
    chk("ill_clear", 32'(err), 32'd0);
    step();

    // Asynchronous reset with two entries buffered and err set
    out_ready = 1'b0;
    in1 = $urandom; sel = 3'd3; in_valid = 1'b1;
    step();
    sel = 3'd7;
    step();
    in_valid = 1'b0;
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    chk("pre_rst_err", 32'(err), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_out1", out1, 32'h0);
    sb.delete();
    step();
    rst = 1'b0;
    in1 = 32'h123450B7; sel = 3'd3; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("post_rst_out1", out1, 32'h12345000);
    chk("post_rst_sel", 32'(out_sel), 32'd3);

    // Drain with a bounded wait
    budget = 0;
    while ((out_valid || sb.size() != 0) && budget < 20) begin
      step();
      budget++;
    end
    chk("drain_timeout", 32'(budget < 20), 32'd1);
    chk("sb_left", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
